// File: rtl/noc_injector.sv
// ============================================================================
// noc_injector : packetising source for one node_port down-link.
// Turns a (destination, N words) request into HEADER / BODY... / TAIL flits
// under the node's enable/ack handshake.
// Optional NOC_INJECTOR_STATS_EN adds packet and stall counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_injector_pkg;
  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } addr_t;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEADER = 2'b01,
    FLIT_TAIL   = 2'b10
  } flit_type_t;

  typedef struct packed {
    flit_type_t           flit_type;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef struct packed {
    logic [PAYLOAD_W-$bits(addr_t)-1:0] rsvd;
    addr_t                              dst_addr;
  } flit_hdr_t;
endpackage

module noc_injector
  import noc_injector_pkg::*;
#(
  parameter int LEN_W  = 4,
  parameter int NODE_X = 1,
  parameter int NODE_Y = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$bits(addr_t)-1:0]  req_dst,
  input  logic [LEN_W-1:0]          req_len_m1,
  input  logic                      pl_valid,
  output logic                      pl_ready,
  input  logic [PAYLOAD_W-1:0]      pl_data,
  output logic [$bits(flit_t)-1:0]  flit,
  output logic                      enable,
  input  logic                      ack
`ifdef NOC_INJECTOR_STATS_EN
  ,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_hdr  = 3'd1;
  localparam logic [2:0] c_data = 3'd2;
  localparam logic [2:0] c_last = 3'd3;
  localparam logic [2:0] c_drop = 3'd4;

  localparam addr_t      c_self      = '{x: NODE_X[COORD_W-1:0], y: NODE_Y[COORD_W-1:0]};
  localparam flit_t      c_idle_flit = '{flit_type: FLIT_BODY, payload: '0};
  localparam logic [LEN_W-1:0] c_one = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state, w_state_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  flit_t            r_flit, w_flit_nxt;
  logic             r_enable, w_enable_nxt;
  logic             w_pl_fire;
  logic             w_step;
  flit_hdr_t        w_hdr;
  flit_t            w_data_flit;

  assign w_pl_fire   = pl_valid && pl_ready;
  assign w_hdr       = '{rsvd: '0, dst_addr: addr_t'(req_dst)};
  assign w_data_flit = '{flit_type: (r_rem == '0) ? FLIT_TAIL : FLIT_BODY, payload: pl_data};
  // HDR advances on ack (first word prefetched); DATA whenever the link slot is free
  assign w_step      = ((r_state == c_hdr) && ack) ||
                       ((r_state == c_data) && (!r_enable || ack));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_flit_nxt   = r_flit;
    w_enable_nxt = r_enable;
    case (r_state)
      c_idle: begin
        if (req_valid && req_ready) begin
          w_rem_nxt = req_len_m1;
          if (addr_t'(req_dst) == c_self) begin
            w_state_nxt = c_drop;
          end else begin
            w_state_nxt  = c_hdr;
            w_enable_nxt = 1'b1;
            w_flit_nxt   = '{flit_type: FLIT_HEADER, payload: w_hdr};
          end
        end
      end
      c_hdr, c_data: begin
        if (w_step) begin
          w_state_nxt = c_data;
          if (w_pl_fire) begin
            w_flit_nxt   = w_data_flit;
            w_enable_nxt = 1'b1;
            if (r_rem == '0) begin
              w_state_nxt = c_last;
            end else begin
              w_rem_nxt = r_rem - c_one;
            end
          end else begin
            // bubble: the wormhole stays open, the link just shows idle
            w_flit_nxt   = c_idle_flit;
            w_enable_nxt = 1'b0;
          end
        end
      end
      c_last: begin
        if (ack) begin
          w_state_nxt  = c_idle;
          w_flit_nxt   = c_idle_flit;
          w_enable_nxt = 1'b0;
        end
      end
      c_drop: begin
        if (w_pl_fire) begin
          if (r_rem == '0) begin
            w_state_nxt = c_idle;
          end else begin
            w_rem_nxt = r_rem - c_one;
          end
        end
      end
      default: begin
        w_state_nxt  = c_idle;
        w_flit_nxt   = c_idle_flit;
        w_enable_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    case (r_state)
      c_idle:  req_ready = rst;
      c_hdr:   pl_ready  = ack;
      c_data:  pl_ready  = !r_enable || ack;
      c_drop:  pl_ready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem    <= '0;
      r_flit   <= c_idle_flit;
      r_enable <= 1'b0;
    end else begin
      r_rem    <= w_rem_nxt;
      r_flit   <= w_flit_nxt;
      r_enable <= w_enable_nxt;
    end
  end

  assign flit   = r_flit;
  assign enable = r_enable;

`ifdef NOC_INJECTOR_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_enable && ack && (r_flit.flit_type == FLIT_TAIL)) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (r_enable && !ack && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign pkt_cnt   = r_pkt_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_injector.sv
// ============================================================================
// tb_noc_injector : directed self-checking bench for noc_injector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_injector;

  localparam logic [1:0] c_t_body = 2'b00;
  localparam logic [1:0] c_t_hdr  = 2'b01;
  localparam logic [1:0] c_t_tail = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_dst;
  logic [3:0]  req_len_m1;
  logic        pl_valid;
  logic        pl_ready;
  logic [15:0] pl_data;
  logic [17:0] flit;
  logic        enable;
  logic        ack;
`ifdef NOC_INJECTOR_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] stall_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] n_words = 16'd0;
  logic [15:0] base;

  always #5 clk = ~clk;

  // Payload source: word value encodes its global sequence number
  always @(posedge clk) if (pl_valid && pl_ready) n_words <= n_words + 16'd1;
  assign pl_data = 16'hA000 + n_words;

  noc_injector #(.LEN_W(4), .NODE_X(1), .NODE_Y(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dst    (req_dst),
    .req_len_m1 (req_len_m1),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .flit       (flit),
    .enable     (enable),
    .ack        (ack)
`ifdef NOC_INJECTOR_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  function automatic logic [17:0] mk(input logic [1:0] t, input logic [15:0] p);
    return {t, p};
  endfunction

  function automatic logic [15:0] w(input logic [15:0] k);
    return 16'hA000 + k;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check link outputs mid-cycle, then advance to just after the next edge
  task automatic chk_out(input string tag, input logic en, input logic [17:0] f, input logic plr);
    @(negedge clk);
    check({tag, ".en"}, {31'd0, enable}, {31'd0, en});
    check({tag, ".flit"}, {14'd0, flit}, {14'd0, f});
    check({tag, ".pl_rdy"}, {31'd0, pl_ready}, {31'd0, plr});
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] dst, input logic [3:0] lm1);
    req_valid  = 1'b1;
    req_dst    = dst;
    req_len_m1 = lm1;
    #1;
    check("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_dst = 8'h00; req_len_m1 = 4'd0;
    pl_valid = 1'b0; ack = 1'b0;
    #2;
    check("rst.en", {31'd0, enable}, 32'd0);
    check("rst.flit", {14'd0, flit}, 32'd0);
    check("rst.req_rdy", {31'd0, req_ready}, 32'd0);
    check("rst.pl_rdy", {31'd0, pl_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle.req_rdy", {31'd0, req_ready}, 32'd1);

    // single packet, steady stream
    ack = 1'b1; pl_valid = 1'b1; base = n_words;
    send_req(8'h23, 4'd2);
    chk_out("t1.hdr", 1'b1, mk(c_t_hdr, 16'h0023), 1'b1);
    chk_out("t1.b0", 1'b1, mk(c_t_body, w(base)), 1'b1);
    chk_out("t1.b1", 1'b1, mk(c_t_body, w(base + 16'd1)), 1'b1);
    chk_out("t1.tail", 1'b1, mk(c_t_tail, w(base + 16'd2)), 1'b0);
    chk_out("t1.idle", 1'b0, 18'd0, 1'b0);

    // backpressure on the header
    ack = 1'b0; base = n_words;
    send_req(8'h23, 4'd2);
    for (int i = 0; i < 3; i++) chk_out("t2.hold", 1'b1, mk(c_t_hdr, 16'h0023), 1'b0);
    ack = 1'b1;
    chk_out("t2.hdr", 1'b1, mk(c_t_hdr, 16'h0023), 1'b1);
    chk_out("t2.b0", 1'b1, mk(c_t_body, w(base)), 1'b1);
    chk_out("t2.b1", 1'b1, mk(c_t_body, w(base + 16'd1)), 1'b1);
    chk_out("t2.tail", 1'b1, mk(c_t_tail, w(base + 16'd2)), 1'b0);
    chk_out("t2.idle", 1'b0, 18'd0, 1'b0);
`ifdef NOC_INJECTOR_STATS_EN
    check("t2.stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    // payload bubble after word A
    base = n_words;
    send_req(8'h23, 4'd2);
    chk_out("t3.hdr", 1'b1, mk(c_t_hdr, 16'h0023), 1'b1);
    pl_valid = 1'b0;
    chk_out("t3.b0", 1'b1, mk(c_t_body, w(base)), 1'b1);
    chk_out("t3.gap0", 1'b0, 18'd0, 1'b1);
    pl_valid = 1'b1;
    chk_out("t3.gap1", 1'b0, 18'd0, 1'b1);
    chk_out("t3.b1", 1'b1, mk(c_t_body, w(base + 16'd1)), 1'b1);
    chk_out("t3.tail", 1'b1, mk(c_t_tail, w(base + 16'd2)), 1'b0);
    chk_out("t3.idle", 1'b0, 18'd0, 1'b0);

    // minimum length
    base = n_words;
    send_req(8'h45, 4'd0);
    chk_out("t4.hdr", 1'b1, mk(c_t_hdr, 16'h0045), 1'b1);
    chk_out("t4.tail", 1'b1, mk(c_t_tail, w(base)), 1'b0);
    chk_out("t4.idle", 1'b0, 18'd0, 1'b0);

    // maximum length: 16 words
    base = n_words;
    send_req(8'h45, 4'd15);
    chk_out("t4m.hdr", 1'b1, mk(c_t_hdr, 16'h0045), 1'b1);
    for (int k = 0; k < 15; k++)
      chk_out("t4m.body", 1'b1, mk(c_t_body, w(base + 16'(k))), 1'b1);
    chk_out("t4m.tail", 1'b1, mk(c_t_tail, w(base + 16'd15)), 1'b0);
    chk_out("t4m.idle", 1'b0, 18'd0, 1'b0);

    // self-addressed: words dropped, link silent
    base = n_words;
    send_req(8'h11, 4'd1);
    chk_out("t5.drop0", 1'b0, 18'd0, 1'b1);
    chk_out("t5.drop1", 1'b0, 18'd0, 1'b1);
    chk_out("t5.done", 1'b0, 18'd0, 1'b0);
    check("t5.words", {16'd0, n_words - base}, 32'd2);
    check("t5.req_rdy", {31'd0, req_ready}, 32'd1);

    // reset in the middle of a packet
    base = n_words;
    send_req(8'h23, 4'd3);
    chk_out("t6.hdr", 1'b1, mk(c_t_hdr, 16'h0023), 1'b1);
    chk_out("t6.b0", 1'b1, mk(c_t_body, w(base)), 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("t6.rst.en", {31'd0, enable}, 32'd0);
    check("t6.rst.flit", {14'd0, flit}, 32'd0);
    check("t6.rst.req_rdy", {31'd0, req_ready}, 32'd0);
    check("t6.rst.pl_rdy", {31'd0, pl_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6.post.req_rdy", {31'd0, req_ready}, 32'd1);
    check("t6.post.en", {31'd0, enable}, 32'd0);

    // back-to-back packets: exactly one idle cycle between them
    base = n_words;
    send_req(8'h32, 4'd0);
    chk_out("t7.hdr0", 1'b1, mk(c_t_hdr, 16'h0032), 1'b1);
    req_valid = 1'b1; req_dst = 8'h54; req_len_m1 = 4'd1;
    #1;
    check("t7.last.req_rdy", {31'd0, req_ready}, 32'd0);
    chk_out("t7.tail0", 1'b1, mk(c_t_tail, w(base)), 1'b0);
    #1;
    check("t7.gap.req_rdy", {31'd0, req_ready}, 32'd1);
    chk_out("t7.gap", 1'b0, 18'd0, 1'b0);
    req_valid = 1'b0;
    chk_out("t7.hdr1", 1'b1, mk(c_t_hdr, 16'h0054), 1'b1);
    chk_out("t7.b1", 1'b1, mk(c_t_body, w(base + 16'd1)), 1'b1);
    chk_out("t7.tail1", 1'b1, mk(c_t_tail, w(base + 16'd2)), 1'b0);
    chk_out("t7.idle", 1'b0, 18'd0, 1'b0);
`ifdef NOC_INJECTOR_STATS_EN
    check("t7.pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
